// File: rtl/uart_rx_cmd_parser.sv
// uart_rx_cmd_parser: framed UART command parser with CRC-8 and CORDIC start/enable/reset control.
// Define UART_RX_CMD_TIMEOUT_EN to abort a message after TIMEOUT_CYC idle cycles between bytes.
module uart_rx_cmd_parser #(
  parameter int         THETA_BYTES = 6,
  parameter logic [7:0] CRC_POLY    = 8'h9B,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_rx_byte,
  input  logic                       i_rx_byte_valid,
  input  logic                       i_rx_err,
  output logic [7:0]                 o_cmd,
  output logic                       o_cmd_valid,
  output logic [7:0]                 o_burst_cnt,
  output logic                       o_burst_cnt_valid,
  output logic                       o_msg_ok,
  output logic                       o_msg_err,
  output logic [1:0]                 o_err_code,
  output logic                       o_cordic_start,
  output logic [8*THETA_BYTES-1:0]   o_cordic_theta,
  output logic                       o_cordic_pipeline_en,
  output logic                       o_cordic_rst_n
);
  localparam int TW = 8 * THETA_BYTES;
  typedef enum logic [2:0] {S_HEADER, S_CMD, S_BURST_N, S_PAYLOAD, S_CRC} state_t;
  state_t        state;
  logic [7:0]    crc, crc_next, sample_cnt;
  logic [3:0]    byte_cnt;
  logic [TW-1:0] stage, stage_next;
  logic          is_burst, byte_ok, last_byte, known, tmo, abort;
  logic [1:0]    abort_code;
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ CRC_POLY) : (x << 1);
    return x;
  endfunction
  assign byte_ok    = i_rx_byte_valid && !i_rx_err;
  assign crc_next   = crc8_byte(crc, i_rx_byte);
  assign stage_next = (stage >> 8) | (TW'(i_rx_byte) << (TW - 8));
  assign last_byte  = byte_cnt == 4'(THETA_BYTES - 1);
  assign known      = i_rx_byte inside {8'hD1, 8'hD2, 8'hE1, 8'hE2};
`ifdef UART_RX_CMD_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC);
  logic [TCW-1:0] idle_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) idle_cnt <= '0;
    else idle_cnt <= (abort || byte_ok || state == S_HEADER) ? '0 : idle_cnt + 1'b1;
  assign tmo = state != S_HEADER && !byte_ok && idle_cnt == TCW'(TIMEOUT_CYC - 1);
`else
  assign tmo = TIMEOUT_CYC < 0;
`endif
  always_comb begin
    abort      = 1'b0;
    abort_code = 2'b00;
    if (i_rx_err && state != S_HEADER) begin
      abort      = 1'b1;
      abort_code = 2'b11;
    end else if (tmo) begin
      abort      = 1'b1;
      abort_code = 2'b10;
    end else if (byte_ok) begin
      abort      = (state == S_CMD && !known) || (state == S_BURST_N && i_rx_byte == 8'h00) ||
                   (state == S_CRC && crc_next != 8'h00);
      abort_code = state == S_CRC ? 2'b01 : 2'b00;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= S_HEADER;
      crc                  <= '0;
      sample_cnt           <= '0;
      byte_cnt             <= '0;
      stage                <= '0;
      is_burst             <= 1'b0;
      o_cmd                <= '0;
      o_cmd_valid          <= 1'b0;
      o_burst_cnt          <= '0;
      o_burst_cnt_valid    <= 1'b0;
      o_msg_ok             <= 1'b0;
      o_msg_err            <= 1'b0;
      o_err_code           <= '0;
      o_cordic_start       <= 1'b0;
      o_cordic_theta       <= '0;
      o_cordic_pipeline_en <= 1'b1;
      o_cordic_rst_n       <= 1'b0;
    end else begin
      o_cmd_valid       <= 1'b0;
      o_burst_cnt_valid <= 1'b0;
      o_msg_ok          <= 1'b0;
      o_msg_err         <= 1'b0;
      o_cordic_start    <= 1'b0;
      o_cordic_rst_n    <= 1'b1;
      if (abort) begin
        o_msg_err      <= 1'b1;
        o_err_code     <= abort_code;
        o_cordic_rst_n <= 1'b0;
        crc            <= '0;
        sample_cnt     <= '0;
        byte_cnt       <= '0;
        stage          <= '0;
        state          <= S_HEADER;
      end else if (i_rx_err) begin
        crc <= '0;
      end else if (byte_ok) begin
        crc <= crc_next;
        case (state)
          S_HEADER: begin
            crc   <= i_rx_byte == 8'h5A ? crc_next : 8'h00;
            state <= i_rx_byte == 8'h5A ? S_CMD : S_HEADER;
          end
          S_CMD: begin
            o_cmd       <= i_rx_byte;
            o_cmd_valid <= 1'b1;
            is_burst    <= i_rx_byte == 8'hD2;
            state       <= i_rx_byte == 8'hD1 ? S_PAYLOAD : i_rx_byte == 8'hD2 ? S_BURST_N : S_CRC;
          end
          S_BURST_N: begin
            o_burst_cnt       <= i_rx_byte;
            o_burst_cnt_valid <= 1'b1;
            sample_cnt        <= i_rx_byte;
            state             <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            stage    <= stage_next;
            byte_cnt <= last_byte ? 4'd0 : byte_cnt + 1'b1;
            if (last_byte) begin
              o_cordic_theta <= stage_next;
              o_cordic_start <= 1'b1;
              sample_cnt     <= is_burst ? sample_cnt - 1'b1 : sample_cnt;
              state          <= (!is_burst || sample_cnt == 8'd1) ? S_CRC : S_PAYLOAD;
            end
          end
          default: begin
            crc                  <= '0;
            o_msg_ok             <= 1'b1;
            o_cordic_pipeline_en <= o_cmd == 8'hE2 ? 1'b1 : o_cmd == 8'hE1 ? 1'b0 : o_cordic_pipeline_en;
            o_cordic_rst_n       <= o_cmd != 8'hE1;
            state                <= S_HEADER;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// tb_uart_rx_cmd_parser: randomized message stimulus with a scoreboard of expected output pulses.
module tb_uart_rx_cmd_parser;
  localparam int         TB   = 6;
  localparam logic [7:0] POLY = 8'h9B;
  localparam int K_NONE = 0, K_CMD = 1, K_BURST = 2, K_START = 3, K_OK = 4, K_ERR = 5;
  localparam int T_SINGLE = 0, T_BURST = 1, T_E1 = 2, T_E2 = 3, T_BADCMD = 4, T_ZERO = 5;
  typedef struct {
    int          kind;
    logic [63:0] val;
    bit          en;
    bit          rst_low;
    logic [47:0] theta;
    logic [1:0]  code;
  } ev_t;
  logic        i_clk = 0, i_rst = 0, i_rx_byte_valid = 0, i_rx_err = 0;
  logic [7:0]  i_rx_byte = 0;
  logic [7:0]  o_cmd, o_burst_cnt;
  logic        o_cmd_valid, o_burst_cnt_valid, o_msg_ok, o_msg_err, o_cordic_start;
  logic [1:0]  o_err_code;
  logic [47:0] o_cordic_theta;
  logic        o_cordic_pipeline_en, o_cordic_rst_n;
  uart_rx_cmd_parser #(.THETA_BYTES(TB), .CRC_POLY(POLY)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid),
    .i_rx_err(i_rx_err), .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .o_burst_cnt(o_burst_cnt),
    .o_burst_cnt_valid(o_burst_cnt_valid), .o_msg_ok(o_msg_ok), .o_msg_err(o_msg_err),
    .o_err_code(o_err_code), .o_cordic_start(o_cordic_start), .o_cordic_theta(o_cordic_theta),
    .o_cordic_pipeline_en(o_cordic_pipeline_en), .o_cordic_rst_n(o_cordic_rst_n)
  );
  always #5 i_clk = ~i_clk;
  ev_t         sb[$];
  ev_t         m_e[$];
  logic [7:0]  m_b[$];
  bit          en_m = 1, seq_payload = 0;
  logic [47:0] theta_m = 0;
  logic [1:0]  code_m = 0;
  int          n_chk = 0, n_fail = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction
  function automatic ev_t mk(int k, logic [63:0] v, bit rl);
    ev_t e;
    e.kind = k; e.val = v; e.en = en_m; e.rst_low = rl; e.theta = theta_m; e.code = code_m;
    return e;
  endfunction
  function automatic void add(logic [7:0] b, ev_t e);
    m_b.push_back(b);
    m_e.push_back(e);
  endfunction
  // Bit-serial polynomial division over the whole message
  function automatic logic [7:0] ref_crc();
    logic [7:0] c;
    bit fb;
    c = 8'h00;
    foreach (m_b[i])
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ m_b[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
      end
    return c;
  endfunction
  function automatic void build(int typ, int n, bit bad, int ferr);
    bit          en_s;
    logic [47:0] th_s, th;
    logic [7:0]  b, c, cmd;
    int          ns;
    en_s = en_m; th_s = theta_m; th = '0;
    m_b.delete(); m_e.delete();
    add(8'h5A, mk(K_NONE, 0, 0));
    cmd = typ == T_SINGLE ? 8'hD1 : (typ == T_BURST || typ == T_ZERO) ? 8'hD2 :
          typ == T_E1 ? 8'hE1 : typ == T_E2 ? 8'hE2 : n[7:0];
    if (typ == T_BADCMD) begin
      code_m = 2'b00;
      add(cmd, mk(K_ERR, 0, 1));
    end else begin
      add(cmd, mk(K_CMD, cmd, 0));
      if (typ == T_ZERO) begin
        code_m = 2'b00;
        add(8'h00, mk(K_ERR, 0, 1));
      end else begin
        if (typ == T_BURST) add(n[7:0], mk(K_BURST, n, 0));
        ns = typ == T_SINGLE ? 1 : typ == T_BURST ? n : 0;
        for (int s = 0; s < ns; s++)
          for (int j = 0; j < TB; j++) begin
            b = seq_payload ? 8'(j + 1) : 8'($urandom);
            th[8*j +: 8] = b;
            if (j == TB - 1) begin
              theta_m = th;
              add(b, mk(K_START, th, 0));
            end else add(b, mk(K_NONE, 0, 0));
          end
        c = ref_crc() ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
        if (bad) begin
          code_m = 2'b01;
          add(c, mk(K_ERR, 1, 1));
        end else begin
          if (typ == T_E1) en_m = 0;
          if (typ == T_E2) en_m = 1;
          add(c, mk(K_OK, 0, typ == T_E1));
        end
      end
    end
    // A framing error drops its byte and aborts; rewind model state to just before it
    if (ferr >= 1 && ferr < m_b.size()) begin
      en_m = en_s; theta_m = th_s;
      for (int i = 0; i < ferr; i++) if (m_e[i].kind == K_START) theta_m = m_e[i].theta;
      code_m = 2'b11;
      m_e[ferr] = mk(K_ERR, 3, 1);
      while (m_b.size() > ferr + 1) begin
        void'(m_b.pop_back());
        void'(m_e.pop_back());
      end
    end
  endfunction
  task automatic send(int ferr, int maxgap);
    for (int i = 0; i < m_b.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge i_clk); #1; end
      i_rx_byte = m_b[i]; i_rx_byte_valid = 1; i_rx_err = (i == ferr);
      if (m_e[i].kind != K_NONE) sb.push_back(m_e[i]);
      @(posedge i_clk); #1;
      i_rx_byte_valid = 0; i_rx_err = 0;
    end
  endtask
  task automatic check_reset();
    chk("rst_cmd", o_cmd, 0);               chk("rst_cmd_valid", o_cmd_valid, 0);
    chk("rst_burst_cnt", o_burst_cnt, 0);   chk("rst_burst_valid", o_burst_cnt_valid, 0);
    chk("rst_msg_ok", o_msg_ok, 0);         chk("rst_msg_err", o_msg_err, 0);
    chk("rst_err_code", o_err_code, 0);     chk("rst_start", o_cordic_start, 0);
    chk("rst_theta", o_cordic_theta, 0);    chk("rst_pipeline_en", o_cordic_pipeline_en, 1);
    chk("rst_cordic_rst_n", o_cordic_rst_n, 0);
  endtask
  task automatic release_reset();
    @(negedge i_clk);
    check_reset();
    #1 i_rst = 0;
    en_m = 1; theta_m = 0; code_m = 0;
    @(posedge i_clk); #1;
    chk("rst_n_rise", o_cordic_rst_n, 1);
  endtask
  always @(negedge i_clk) begin
    int  np, k;
    ev_t e;
    if (!i_rst) begin
      np = int'(o_cmd_valid) + int'(o_burst_cnt_valid) + int'(o_cordic_start) + int'(o_msg_ok) + int'(o_msg_err);
      k  = o_msg_err ? K_ERR : o_msg_ok ? K_OK : o_cordic_start ? K_START : o_burst_cnt_valid ? K_BURST :
           o_cmd_valid ? K_CMD : K_NONE;
      if (np == 0) chk("rst_n_idle", o_cordic_rst_n, 1);
      else if (np > 1) chk("single_pulse", np, 1);
      else if (sb.size() == 0) chk("unexpected_pulse", k, K_NONE);
      else begin
        e = sb.pop_front();
        chk("pulse_kind", k, e.kind);
        if (k == K_CMD) chk("cmd", o_cmd, e.val);
        if (k == K_BURST) chk("burst_cnt", o_burst_cnt, e.val);
        if (k == K_ERR) chk("err_code_on_err", o_err_code, e.val);
        chk("theta", o_cordic_theta, e.theta);
        chk("pipeline_en", o_cordic_pipeline_en, e.en);
        chk("cordic_rst_n", o_cordic_rst_n, !e.rst_low);
        chk("err_code_held", o_err_code, e.code);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected pulses pending", sb.size());
    $fatal(1, "watchdog");
  end
  initial begin
    int         typ, n, ferr;
    bit         bad;
    logic [7:0] c;
    #1 i_rst = 1;
    repeat (3) @(posedge i_clk);
    release_reset();
    seq_payload = 1;
    build(T_SINGLE, 1, 0, -1);   send(-1, 0);
    seq_payload = 0;
    build(T_BURST, 3, 0, -1);    send(-1, 0);
    build(T_E1, 0, 1, -1);       send(-1, 1);
    build(T_E1, 0, 0, -1);       send(-1, 0);
    build(T_E2, 0, 0, -1);       send(-1, 2);
    build(T_BADCMD, 8'h77, 0, -1); send(-1, 0);
    build(T_ZERO, 0, 0, -1);     send(-1, 0);
    build(T_SINGLE, 1, 0, 4);    send(4, 0);
    build(T_SINGLE, 1, 0, -1);   send(-1, 0);
    i_rx_byte = 8'h5A; i_rx_byte_valid = 1; i_rx_err = 1;
    @(posedge i_clk); #1;
    i_rx_byte_valid = 0; i_rx_err = 0;
    build(T_SINGLE, 1, 0, -1);   send(-1, 1);
    for (int m = 0; m < 200; m++) begin
      if ($urandom_range(0, 4) == 0)
        repeat ($urandom_range(1, 4)) begin
          do c = 8'($urandom); while (c == 8'h5A);
          i_rx_byte = c; i_rx_byte_valid = 1;
          @(posedge i_clk); #1;
          i_rx_byte_valid = 0;
        end
      typ = $urandom_range(0, 5);
      n = $urandom_range(1, 4);
      if (typ == T_BADCMD) begin
        do c = 8'($urandom); while (c inside {8'hD1, 8'hD2, 8'hE1, 8'hE2});
        n = int'(c);
      end
      bad  = $urandom_range(0, 5) == 0;
      ferr = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 30)) : -1;
      build(typ, n, bad, ferr);
      send(ferr, 2);
    end
    build(T_BURST, 255, 0, -1);  send(-1, 0);
    build(T_E1, 0, 0, -1);       send(-1, 0);
    build(T_SINGLE, 1, 0, -1);
    while (m_b.size() > 4) begin
      void'(m_b.pop_back());
      void'(m_e.pop_back());
    end
    send(-1, 0);
    repeat (3) @(posedge i_clk);
    #1 chk("queue_empty_before_reset", sb.size(), 0);
    i_rst = 1;
    @(posedge i_clk); #1;
    release_reset();
    build(T_SINGLE, 1, 0, -1);   send(-1, 0);
    build(T_BURST, 2, 0, -1);    send(-1, 1);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
